// File: rtl/tile_map_sequencer.sv
// Tile map sequencer: walks a row-major tile map in a synchronous ROM and issues
// one draw request per non-empty cell to a downstream 8x8 tile drawer.
module tile_map_sequencer #(
  parameter int          MAP_COLS   = 20,
  parameter int          MAP_ROWS   = 15,
  parameter logic [9:0]  MAP_BASE   = 10'd0,
  parameter logic [15:0] TILE_BASE  = 16'd0,
  parameter logic [7:0]  SKIP_INDEX = 8'hFF,
  parameter int          TIMEOUT    = 1023
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  output logic [9:0]  map_address,
  input  logic [7:0]  map_data,
  output logic [15:0] tile_address,
  output logic [7:0]  x_pos,
  output logic [7:0]  y_pos,
  output logic        draw,
  input  logic        tile_done,
  output logic        busy,
  output logic        frame_done,
  output logic        error
);

  localparam int         CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [4:0] LAST_COL = 5'(MAP_COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(MAP_ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_DECIDE,
    S_ISSUE,
    S_WAIT_DONE,
    S_ADVANCE,
    S_FINISH
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [4:0]         r_col;
  logic [4:0]         r_row;
  logic [CNT_W-1:0]   r_cnt;
  logic [7:0]         r_index;
  logic [9:0]         r_map_addr;
  logic [15:0]        r_tile_addr;
  logic [7:0]         r_x;
  logic [7:0]         r_y;
  logic               r_error;

  logic w_last_col;
  logic w_last_cell;
  logic w_skip;
  logic w_terminal;

  assign w_last_col  = (r_col == LAST_COL);
  assign w_last_cell = w_last_col && (r_row == LAST_ROW);
  assign w_skip      = (r_index == SKIP_INDEX);
  assign w_terminal  = (r_cnt == CNT_W'(TIMEOUT - 1));

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic.
  // NOTE: assigning w_next a default first keeps this block free of inferred latches.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (start) w_next = S_FETCH;
      S_FETCH:     w_next = S_LATCH;
      S_LATCH:     w_next = S_DECIDE;
      S_DECIDE:    w_next = w_skip ? S_ADVANCE : S_ISSUE;
      S_ISSUE:     w_next = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (tile_done)       w_next = S_ADVANCE;
        else if (w_terminal) w_next = S_IDLE;
      end
      S_ADVANCE:   w_next = w_last_cell ? S_FINISH : S_FETCH;
      S_FINISH:    w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // Outputs decoded straight from the state so draw drops the instant reset asserts.
  always_comb begin
    draw       = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    case (r_state)
      S_IDLE:   busy       = 1'b0;
      S_ISSUE:  draw       = 1'b1;
      S_FINISH: frame_done = 1'b1;
      default:  ;
    endcase
  end

  // Cell position, map/tile addresses, timeout counter and sticky error.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_col       <= '0;
      r_row       <= '0;
      r_cnt       <= '0;
      r_index     <= '0;
      r_map_addr  <= MAP_BASE;
      r_tile_addr <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_error     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_col      <= '0;
            r_row      <= '0;
            r_map_addr <= MAP_BASE;
            r_error    <= 1'b0;
          end
        end
        S_LATCH: r_index <= map_data;
        S_DECIDE: begin
          if (!w_skip) begin
            r_tile_addr <= TILE_BASE + {2'b00, r_index, 6'b0};
            r_x         <= {r_col, 3'b000};
            r_y         <= {r_row, 3'b000};
            r_cnt       <= '0;
          end
        end
        S_WAIT_DONE: begin
          // A completion arriving on the terminal count still counts as success.
          if (!tile_done) begin
            if (w_terminal) r_error <= 1'b1;
            else            r_cnt   <= r_cnt + 1'b1;
          end
        end
        S_ADVANCE: begin
          if (!w_last_cell) begin
            if (w_last_col) begin
              r_col <= '0;
              r_row <= r_row + 5'd1;
            end else begin
              r_col <= r_col + 5'd1;
            end
            r_map_addr <= r_map_addr + 10'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign map_address  = r_map_addr;
  assign tile_address = r_tile_addr;
  assign x_pos        = r_x;
  assign y_pos        = r_y;
  assign error        = r_error;

endmodule

// File: tb/tb_tile_map_sequencer.sv
// Self-checking bench for tile_map_sequencer: ROM + drawer models, and a
// map-level reference model predicting draw order, origins and frame length.
module tb_tile_map_sequencer;

  localparam int          COLS   = 2;
  localparam int          ROWS   = 2;
  localparam logic [9:0]  A_BASE = 10'd4;
  localparam logic [15:0] A_TILE = 16'd0;
  localparam int          A_TO   = 16;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic start = 1'b0;

  logic [9:0]  a_map_address;
  logic [7:0]  a_map_data = 8'h00;
  logic [15:0] a_tile_address;
  logic [7:0]  a_x_pos, a_y_pos;
  logic        a_draw, a_tile_done, a_busy, a_frame_done, a_error;

  logic [9:0]  b_map_address;
  logic [7:0]  b_map_data;
  logic [15:0] b_tile_address;
  logic [7:0]  b_x_pos, b_y_pos;
  logic        b_draw, b_busy, b_frame_done, b_error;
  logic        b_tile_done = 1'b0;

  logic [7:0]  rom_a [4];
  logic        drv_done = 1'b0;
  logic        spur_done = 1'b0;
  int          drv_lat = 10;
  int          dcnt = 0;

  int          n_cmp = 0;
  int          n_err = 0;
  int          busy_cnt = 0;
  int          fd_cnt = 0;
  logic [31:0] obs_q[$];
  logic [15:0] b_q[$];

  always #5 clk = ~clk;

  tile_map_sequencer #(
    .MAP_COLS(COLS), .MAP_ROWS(ROWS), .MAP_BASE(A_BASE), .TILE_BASE(A_TILE),
    .SKIP_INDEX(8'hFF), .TIMEOUT(A_TO)
  ) dut_a (
    .clk(clk), .resetn(resetn), .start(start),
    .map_address(a_map_address), .map_data(a_map_data),
    .tile_address(a_tile_address), .x_pos(a_x_pos), .y_pos(a_y_pos),
    .draw(a_draw), .tile_done(a_tile_done), .busy(a_busy),
    .frame_done(a_frame_done), .error(a_error)
  );

  // Single-cell instance exercising 16-bit wrap of the tile address.
  tile_map_sequencer #(
    .MAP_COLS(1), .MAP_ROWS(1), .MAP_BASE(10'd0), .TILE_BASE(16'hF000),
    .SKIP_INDEX(8'hFF), .TIMEOUT(1023)
  ) dut_b (
    .clk(clk), .resetn(resetn), .start(start),
    .map_address(b_map_address), .map_data(b_map_data),
    .tile_address(b_tile_address), .x_pos(b_x_pos), .y_pos(b_y_pos),
    .draw(b_draw), .tile_done(b_tile_done), .busy(b_busy),
    .frame_done(b_frame_done), .error(b_error)
  );

  assign b_map_data  = 8'hC0;
  assign a_tile_done = drv_done | spur_done;

  // Synchronous map ROM: data follows the address by one clock.
  always @(posedge clk) begin
    a_map_data <= ((a_map_address - A_BASE) < 10'd4) ? rom_a[2'(a_map_address - A_BASE)] : 8'h00;
    b_tile_done <= b_draw;
  end

  // Drawer: tile_done is seen by the DUT drv_lat cycles after the draw cycle; 0 = never.
  initial forever begin
    @(negedge clk);
    drv_done = 1'b0;
    if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0) drv_done = 1'b1;
    end
    if (a_draw && drv_lat > 0) dcnt = drv_lat;
  end

  initial forever begin
    @(negedge clk);
    if (a_draw) obs_q.push_back({a_tile_address, a_x_pos, a_y_pos});
    if (a_busy) busy_cnt++;
    if (a_frame_done) fd_cnt++;
    if (b_draw) b_q.push_back(b_tile_address);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic run_frame(input int lat, input bit spur, input int mid_start,
                           output int got_busy, output int got_fd, output int base_q);
    int b0, f0;
    drv_lat = lat;
    base_q  = obs_q.size();
    b0      = busy_cnt;
    f0      = fd_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", 32'(a_busy), 32'd1);
    check("error_cleared_by_start", 32'(a_error), 32'd0);
    if (spur) begin
      spur_done = 1'b1;
      repeat (3) tick();
      spur_done = 1'b0;
    end
    for (int n = 0; n < 3000; n++) begin
      if (!a_busy) break;
      if (mid_start > 0 && n == mid_start) start = 1'b1;
      if (n == mid_start + 2) start = 1'b0;
      tick();
    end
    start = 1'b0;
    check("frame_ends_in_idle", 32'(a_busy), 32'd0);
    got_busy = busy_cnt - b0;
    got_fd   = fd_cnt - f0;
  endtask

  // Reference: row-major walk over rom_a, skip cells cost 4, drawn cells 5+lat, plus FINISH.
  task automatic compare_frame(input string tag, input int lat, input int base_q,
                               input int got_busy, input int got_fd);
    logic [31:0] exp_q[$];
    logic [31:0] got;
    int          exp_busy;
    exp_busy = 1;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (rom_a[r*COLS + c] == 8'hFF) begin
          exp_busy += 4;
        end else begin
          exp_busy += 5 + lat;
          exp_q.push_back({16'(int'(A_TILE) + int'(rom_a[r*COLS + c]) * 64), 8'(c*8), 8'(r*8)});
        end
      end
    end
    check({tag, "_busy_cycles"}, 32'(got_busy), 32'(exp_busy));
    check({tag, "_frame_done_count"}, 32'(got_fd), 32'd1);
    check({tag, "_draw_count"}, 32'(obs_q.size() - base_q), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (base_q + i < obs_q.size()) ? obs_q[base_q + i] : 32'hxxxxxxxx;
      check($sformatf("%s_draw%0d", tag, i), got, exp_q[i]);
    end
    check({tag, "_no_error"}, 32'(a_error), 32'd0);
  endtask

  initial begin
    int gb, gf, bq;
    int lat;
    int b0;

    rom_a[0] = 8'd3; rom_a[1] = 8'd5; rom_a[2] = 8'd7; rom_a[3] = 8'd1;
    repeat (3) tick();
    check("rst_draw", 32'(a_draw), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_frame_done", 32'(a_frame_done), 32'd0);
    check("rst_error", 32'(a_error), 32'd0);
    check("rst_tile_address", 32'(a_tile_address), 32'd0);
    check("rst_x_pos", 32'(a_x_pos), 32'd0);
    check("rst_y_pos", 32'(a_y_pos), 32'd0);
    check("rst_map_address", 32'(a_map_address), 32'(A_BASE));
    resetn = 1'b1;
    repeat (3) tick();
    check("idle_without_start", 32'(a_busy), 32'd0);

    run_frame(10, 1'b0, 0, gb, gf, bq);
    compare_frame("basic", 10, bq, gb, gf);
    check("wrap_draw_seen", 32'(b_q.size() != 0), 32'd1);
    check("wrap_tile_address", (b_q.size() != 0) ? 32'(b_q[0]) : 32'hxxxxxxxx, 32'h2000);

    rom_a[1] = 8'hFF;
    run_frame(10, 1'b0, 0, gb, gf, bq);
    compare_frame("skip", 10, bq, gb, gf);

    rom_a[1] = 8'd5;
    run_frame(10, 1'b1, 20, gb, gf, bq);
    compare_frame("busy_start_spur", 10, bq, gb, gf);

    run_frame(16, 1'b0, 0, gb, gf, bq);
    compare_frame("done_on_terminal", 16, bq, gb, gf);

    // Drawer never answers: 4 cycles to ISSUE, then 16 WAIT_DONE cycles, then abort.
    run_frame(0, 1'b0, 0, gb, gf, bq);
    check("timeout_busy_cycles", 32'(gb), 32'd20);
    check("timeout_no_frame_done", 32'(gf), 32'd0);
    check("timeout_error", 32'(a_error), 32'd1);
    check("timeout_draw_count", 32'(obs_q.size() - bq), 32'd1);
    check("timeout_first_draw", (obs_q.size() > bq) ? obs_q[bq] : 32'hxxxxxxxx, 32'h00C0_0000);

    run_frame(0, 1'b0, 0, gb, gf, bq);
    check("timeout2_error", 32'(a_error), 32'd1);
    #2 resetn = 1'b0;
    #1 check("async_rst_error", 32'(a_error), 32'd0);
    tick();
    resetn = 1'b1;
    tick();

    drv_lat = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (a_draw) break;
      tick();
    end
    check("issue_reached", 32'(a_draw), 32'd1);
    resetn = 1'b0;
    #1;
    check("async_rst_draw", 32'(a_draw), 32'd0);
    check("async_rst_busy", 32'(a_busy), 32'd0);
    check("async_rst_map_address", 32'(a_map_address), 32'(A_BASE));
    repeat (2) tick();
    resetn = 1'b1;
    b0 = busy_cnt;
    bq = obs_q.size();
    repeat (6) tick();
    check("post_rst_stays_idle", 32'(busy_cnt - b0), 32'd0);
    check("post_rst_no_draw", 32'(obs_q.size() - bq), 32'd0);

    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 4; i++)
        rom_a[i] = (k == 3 || $urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      lat = int'($urandom_range(1, 16));
      run_frame(lat, 1'b0, 0, gb, gf, bq);
      compare_frame($sformatf("rand%0d", k), lat, bq, gb, gf);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
